// File: rtl/memoria_amostras_pkg.sv
// Shared definitions for the sample memory: load FSM encodings and address-space sizing.
// The optional parity feature is controlled by MEMORIA_PARIDADE_EN (see memoria_amostras.sv).
package memoria_pkg;

   localparam int ADDR_W    = 6;
   localparam int MEM_DEPTH = 64;

   typedef enum logic [1:0] {
      OCIOSO     = 2'b00,
      CARREGANDO = 2'b01,
      CONCLUIDO  = 2'b10
   } estado_t;

endpackage : memoria_pkg

// File: rtl/memoria_amostras_if.sv
// Load/read bus between the transform controller (master) and the sample memory (slave).
// Parity_Error exists only when MEMORIA_PARIDADE_EN is defined.
interface memoria_amostras_if
   import memoria_pkg::*;
#(
   parameter int DATA_WIDTH = 8
);

   logic                  Load_Start;
   logic                  Load_Valid;
   logic [DATA_WIDTH-1:0] Load_Data;
   logic                  Load_Ready;
   logic                  Load_Done;
   logic                  Read_Enable;
   logic [ADDR_W-1:0]     Address;
   logic [DATA_WIDTH-1:0] Data_Out;
   logic                  Data_Valid;
   logic                  Read_Error;
`ifdef MEMORIA_PARIDADE_EN
   logic                  Parity_Error;
`endif

   modport master (
      output Load_Start, Load_Valid, Load_Data, Read_Enable, Address,
`ifdef MEMORIA_PARIDADE_EN
      input  Parity_Error,
`endif
      input  Load_Ready, Load_Done, Data_Out, Data_Valid, Read_Error
   );

   modport slave (
      input  Load_Start, Load_Valid, Load_Data, Read_Enable, Address,
`ifdef MEMORIA_PARIDADE_EN
      output Parity_Error,
`endif
      output Load_Ready, Load_Done, Data_Out, Data_Valid, Read_Error
   );

endinterface : memoria_amostras_if

// File: rtl/memoria_amostras_ram.sv
// Ram_Simples: single-port storage with synchronous write and registered read.
// Under MEMORIA_PARIDADE_EN each word carries an even-parity bit checked on read.
module ram_simples
   import memoria_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = MEM_DEPTH
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Write_Enable,
   input  logic                  Read_Enable,
   input  logic [ADDR_W-1:0]     Address,
   input  logic [DATA_WIDTH-1:0] Write_Data,
`ifdef MEMORIA_PARIDADE_EN
   output logic                  Parity_Error,
`endif
   output logic [DATA_WIDTH-1:0] Read_Data
);

`ifdef MEMORIA_PARIDADE_EN
   localparam int WORD_W = DATA_WIDTH + 1;

   function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
      return ^word;
   endfunction

   logic parity_err_r;
`else
   localparam int WORD_W = DATA_WIDTH;
`endif

   logic [WORD_W-1:0]     mem_r [DEPTH];
   logic [WORD_W-1:0]     wr_word_s;
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Build the stored word (data plus parity bit when enabled)
   always_comb begin
`ifdef MEMORIA_PARIDADE_EN
      wr_word_s = {even_parity(Write_Data), Write_Data};
`else
      wr_word_s = Write_Data;
`endif
   end

   // Storage array: never reset, contents survive Reset
   always_ff @(posedge Clock) begin
      if (Write_Enable) begin
         mem_r[Address] <= wr_word_s;
      end
   end

   // Read register holds its value between reads; cleared only by Reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_data_r <= '0;
`ifdef MEMORIA_PARIDADE_EN
         parity_err_r <= 1'b0;
`endif
      end else begin
         if (Read_Enable) begin
            rd_data_r <= mem_r[Address][DATA_WIDTH-1:0];
         end
`ifdef MEMORIA_PARIDADE_EN
         // Whole stored word must XOR to zero under even parity
         parity_err_r <= Read_Enable & (^mem_r[Address]);
`endif
      end
   end

   assign Read_Data = rd_data_r;
`ifdef MEMORIA_PARIDADE_EN
   assign Parity_Error = parity_err_r;
`endif

endmodule : ram_simples

// File: rtl/memoria_amostras.sv
// Memoria_Amostras: 64-word 8x8 sample buffer with a block-load FSM and 1-cycle read port.
// Optional MEMORIA_PARIDADE_EN adds per-word even parity and the Parity_Error pulse.
module memoria_amostras
   import memoria_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = MEM_DEPTH
)(
   input  logic               Clock,
   input  logic               Reset,
   memoria_amostras_if.slave  bus
);

   estado_t           state_r;
   logic [ADDR_W-1:0] wr_cnt_r;
   logic [ADDR_W-1:0] ram_addr_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic              load_ready_r;
   logic              load_done_r;
   logic              data_valid_r;
   logic              read_error_r;

   // Single RAM port: the write counter owns it while loading, reads get it otherwise
   always_comb begin
      wr_en_s    = 1'b0;
      rd_en_s    = 1'b0;
      ram_addr_s = bus.Address;
      if (state_r == CARREGANDO) begin
         wr_en_s    = bus.Load_Valid;
         ram_addr_s = wr_cnt_r;
      end else begin
         rd_en_s    = bus.Read_Enable;
      end
   end

   // Load FSM with registered handshake and read-response flags
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r      <= OCIOSO;
         wr_cnt_r     <= 6'd0;
         load_ready_r <= 1'b0;
         load_done_r  <= 1'b0;
         data_valid_r <= 1'b0;
         read_error_r <= 1'b0;
      end else begin
         data_valid_r <= rd_en_s;
         read_error_r <= bus.Read_Enable & (state_r == CARREGANDO);
         load_done_r  <= 1'b0;
         case (state_r)
            OCIOSO: begin
               if (bus.Load_Start) begin
                  state_r      <= CARREGANDO;
                  wr_cnt_r     <= 6'd0;
                  load_ready_r <= 1'b1;
               end else begin
                  load_ready_r <= 1'b0;
               end
            end
            CARREGANDO: begin
               if (bus.Load_Valid) begin
                  wr_cnt_r <= wr_cnt_r + 6'd1;
                  if (wr_cnt_r == 6'd63) begin
                     state_r      <= CONCLUIDO;
                     load_ready_r <= 1'b0;
                     load_done_r  <= 1'b1;
                  end
               end
            end
            CONCLUIDO: begin
               state_r      <= OCIOSO;
               load_ready_r <= 1'b0;
            end
            default: begin
               state_r      <= OCIOSO;
               wr_cnt_r     <= 6'd0;
               load_ready_r <= 1'b0;
            end
         endcase
      end
   end

   ram_simples #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .Clock        (Clock),
      .Reset        (Reset),
      .Write_Enable (wr_en_s),
      .Read_Enable  (rd_en_s),
      .Address      (ram_addr_s),
      .Write_Data   (bus.Load_Data),
`ifdef MEMORIA_PARIDADE_EN
      .Parity_Error (bus.Parity_Error),
`endif
      .Read_Data    (bus.Data_Out)
   );

   assign bus.Load_Ready = load_ready_r;
   assign bus.Load_Done  = load_done_r;
   assign bus.Data_Valid = data_valid_r;
   assign bus.Read_Error = read_error_r;

endmodule : memoria_amostras

// File: doc/memoria_amostras.md
MEMORIA_AMOSTRAS -- requirements
Module: Memoria_Amostras

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the sample word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the number of words; it is fixed at 64 and equals the 8x8 {u,v} address space.
REQ-003 Port: Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: Load_Start  input  1  request to load a full 64-word block.
REQ-006 Port: Load_Valid  input  1  Load_Data is valid this cycle.
REQ-007 Port: Load_Data  input  DATA_WIDTH  word to write.
REQ-008 Port: Load_Ready  output  1  the block accepts a load word this cycle.
REQ-009 Port: Load_Done  output  1  one-cycle pulse after the 64th word is written.
REQ-010 Port: Read_Enable  input  1  read request from the transform controller.
REQ-011 Port: Address  input  6  read address {u[2:0], v[2:0]}.
REQ-012 Port: Data_Out  output  DATA_WIDTH  read data.
REQ-013 Port: Data_Valid  output  1  one-cycle pulse; Data_Out holds the result of the previous-cycle read.
REQ-014 Port: Read_Error  output  1  one-cycle pulse; the previous-cycle read was rejected.

Function
REQ-015 The load FSM SHALL have three states:
- Ocioso (00)
- Carregando (01)
- Concluido (10)
- the unused encoding SHALL go to Ocioso.
REQ-016 Ocioso SHALL go to Carregando when Load_Start=1, and otherwise remain in Ocioso.
REQ-017 In Carregando, Load_Ready SHALL be 1, and each cycle with Load_Valid=1 SHALL write Load_Data at the write counter and then increment the counter.
REQ-018 The write counter SHALL be 6 bits, SHALL start at 0 on entry to Carregando, and the write at counter 63 SHALL move the FSM to Concluido with the counter wrapping to 0.
REQ-019 Concluido SHALL assert Load_Done for exactly one cycle and then go to Ocioso unconditionally.
REQ-020 Load_Start SHALL be ignored in Carregando and Concluido.
REQ-021 In Carregando, cycles with Load_Valid=0 SHALL neither write nor advance the counter; there is no timeout.
REQ-022 Outside Carregando, Load_Ready SHALL be 0 and Load_Valid/Load_Data SHALL be ignored.
REQ-023 Read latency SHALL be exactly one cycle: Read_Enable=1 at edge N SHALL give Data_Out=mem[Address] and Data_Valid=1 after edge N+1.
REQ-024 A read requested while the FSM is in Carregando SHALL be rejected: Data_Valid=0, Read_Error=1 one cycle later, and Data_Out unchanged.
REQ-025 A read in the same cycle as Load_Start in Ocioso SHALL be served from the pre-load contents.
REQ-026 A read in Concluido SHALL return the newly loaded contents.
REQ-027 Data_Out SHALL hold its last value between reads.
REQ-028 Back-to-back reads on consecutive cycles SHALL each be served.
REQ-029 The read address SHALL use all 6 bits, so any value is valid and there is no out-of-range case.

Reset
REQ-030 Reset SHALL force, immediately and asynchronously:
- FSM to Ocioso
- write counter to 0
- Load_Ready, Load_Done, Data_Valid, Read_Error to 0
- Data_Out to 0.
REQ-031 Memory contents SHALL NOT be cleared by Reset.
REQ-032 A reset in mid-load SHALL abort the load, keep words already written, and require a new Load_Start.

Configuration
REQ-033 With macro MEMORIA_PARIDADE_EN defined:
- each word SHALL be stored with an even-parity bit computed at write
- an output Parity_Error (1 bit) SHALL pulse alongside Data_Valid when the stored parity mismatches
- Parity_Error SHALL reset to 0.
REQ-034 Without MEMORIA_PARIDADE_EN, no parity storage and no Parity_Error port SHALL exist.

Structure
REQ-035 A shared package Memoria_Pkg SHALL hold:
- FSM state encodings
- address width 6
- depth 64.
REQ-036 The storage array SHALL be one sub-module, Ram_Simples: single-port, synchronous write, registered read, with width DATA_WIDTH (+1 under parity).
REQ-037 The load FSM and read-response logic SHALL reside in Memoria_Amostras.

Verification
REQ-038 Load words 0..63 with Load_Valid=1 every cycle -> Load_Done pulses one cycle after the 64th write; reading every address returns the value equal to that address.
REQ-039 Load with Load_Valid toggling 1/0 -> exactly 64 accepted words, Load_Done after the 64th accepted word, and no extra writes.
REQ-040 Read_Enable=1 with Address=6'b101_011 after a full load -> next cycle Data_Out=43 and Data_Valid=1; Data_Out holds 43 on the following idle cycles.
REQ-041 Read_Enable=1 in Carregando -> next cycle Read_Error=1, Data_Valid=0, Data_Out unchanged.
REQ-042 Reset asserted after 10 load words -> FSM in Ocioso and outputs 0; a new Load_Start loads from address 0; the old words 10..63 are still readable if no reload follows.
REQ-043 With MEMORIA_PARIDADE_EN, force a stored parity bit flip at address 5, then read address 5 -> Parity_Error=1 together with Data_Valid=1.
